// File: rtl/projection_scheduler_pkg.sv
// Shared types and helpers for the projection scheduler and its round-robin arbiter.
package proj_pkg;

  localparam int COORD_W = 16;
  localparam int BBOX_W  = 6 * COORD_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    HOLD      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Bit offset of requester idx's box inside the flattened req_bbox bus
  function automatic int bbox_lsb(input int idx, input int coord_w);
    return idx * 6 * coord_w;
  endfunction

endpackage

// File: rtl/projection_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  // Scan from the farthest offset down so the closest requester to ptr is written last
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt    = NREQ'(1) << ((int'(ptr) + k) % NREQ);
        gnt_id = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/projection_scheduler.sv
// Round-robin scheduler sharing one bounding-box projection unit among NREQ producers.
module projection_scheduler #(
  parameter int NREQ         = 4,
  parameter int COORD_W      = 16,
  parameter int ACK_TIMEOUT  = 16,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*6*COORD_W-1:0] req_bbox,
  output logic                      proj_valid_in,
  input  logic                      proj_ready_out,
  output logic [COORD_W-1:0]        proj_min_x,
  output logic [COORD_W-1:0]        proj_min_y,
  output logic [COORD_W-1:0]        proj_min_z,
  output logic [COORD_W-1:0]        proj_max_x,
  output logic [COORD_W-1:0]        proj_max_y,
  output logic [COORD_W-1:0]        proj_max_z,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [15:0]               issued_cnt,
  output logic                      err_timeout
);
  import proj_pkg::*;

  localparam int IDW   = $clog2(NREQ);
  localparam int TW    = $clog2(DONE_TIMEOUT + 1);
  localparam int BOX_W = 6 * COORD_W;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   arb_id;
  logic [NREQ-1:0]  arb_gnt;
  logic             arb_any;
  logic [TW-1:0]    timer;
  logic [BOX_W-1:0] box_q;
  logic             grant;
  logic             timeout_hit;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // rst gating keeps req_ready low immediately, even though IDLE is already forced
  assign grant     = (state == IDLE) & enable & proj_ready_out & arb_any & ~rst;
  assign req_ready = grant ? arb_gnt : '0;
  assign busy      = (state != IDLE);

  assign proj_min_x = box_q[0*COORD_W +: COORD_W];
  assign proj_min_y = box_q[1*COORD_W +: COORD_W];
  assign proj_min_z = box_q[2*COORD_W +: COORD_W];
  assign proj_max_x = box_q[3*COORD_W +: COORD_W];
  assign proj_max_y = box_q[4*COORD_W +: COORD_W];
  assign proj_max_z = box_q[5*COORD_W +: COORD_W];

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE:  if (grant) state_nx = ISSUE;
      ISSUE: state_nx = HOLD;
      HOLD: begin
        if (!proj_ready_out) begin
          state_nx = WAIT_DONE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          state_nx    = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (proj_ready_out) begin
          state_nx = IDLE;
        end else if (timer == TW'(DONE_TIMEOUT - 1)) begin
          state_nx    = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Timer restarts on every state change, so HOLD and WAIT_DONE each count from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      box_q         <= '0;
      grant_id      <= '0;
      proj_valid_in <= 1'b0;
      issued_cnt    <= '0;
      timer         <= '0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= state_nx;
      proj_valid_in <= (state_nx == ISSUE);
      if (grant) begin
        box_q    <= req_bbox[bbox_lsb(int'(arb_id), COORD_W) +: BOX_W];
        grant_id <= arb_id;
        rr_ptr   <= IDW'((int'(arb_id) + 1) % NREQ);
      end
      if (state == ISSUE) issued_cnt <= issued_cnt + 16'd1;
      if (state_nx != state) begin
        timer <= '0;
      end else if (state == HOLD || state == WAIT_DONE) begin
        timer <= timer + TW'(1);
      end
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

endmodule
